// File: rtl/adventure_pkg.sv
// adventure_pkg: room/direction types and the fixed seven-room map shared by the adventure engine.
`default_nettype none

package adventure_pkg;

    typedef enum logic [2:0] {
        CAVE    = 3'd0,
        TUNNEL  = 3'd1,
        RIVER   = 3'd2,
        ARMORY  = 3'd3,
        DRAGON  = 3'd4,
        VICTORY = 3'd5,
        DEATH   = 3'd6,
        ILLEGAL = 3'd7
    } room_t;

    typedef enum logic [3:0] {
        DIR_NONE = 4'b0000,
        DIR_N    = 4'b1000,
        DIR_S    = 4'b0100,
        DIR_E    = 4'b0010,
        DIR_W    = 4'b0001
    } dir_t;

    // A blocked direction (and every terminal room) returns the current room unchanged.
    function automatic room_t next_room(input room_t cur, input dir_t dir, input logic has_sword);
        room_t dest;
        dest = cur;
        case (cur)
            CAVE:   if (dir == DIR_S) dest = TUNNEL;
            TUNNEL: begin
                if (dir == DIR_S)      dest = RIVER;
                else if (dir == DIR_W) dest = CAVE;
            end
            RIVER:  begin
                if (dir == DIR_N)      dest = TUNNEL;
                else if (dir == DIR_W) dest = ARMORY;
                else if (dir == DIR_E) dest = DRAGON;
            end
            ARMORY: if (dir == DIR_E) dest = RIVER;
            DRAGON: begin
                if (dir == DIR_W)      dest = ARMORY;
                else if (dir == DIR_E) dest = has_sword ? VICTORY : DEATH;
            end
            default: dest = cur;
        endcase
        return dest;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adventure_dir_decode.sv
// adventure_dir_decode: registers the N/S/E/W buttons and turns them into a single validated press.
`default_nettype none

module adventure_dir_decode
    import adventure_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [3:0] btn_i,
    output logic       valid_o,
    output dir_t       dir_o
);

    logic [3:0] dir_q;
    logic [3:0] press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        dir_q <= '0;
        else if (start_i) dir_q <= '0;
        else              dir_q <= btn_i;
    end

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic [3:0] dir_qq;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)        dir_qq <= '0;
                else if (start_i) dir_qq <= '0;
                else              dir_qq <= dir_q;
            end
            assign press = dir_q & ~dir_qq;
        end else begin : g_level
            assign press = dir_q;
        end
    endgenerate

    // Chords of two or more buttons are dropped entirely rather than resolved.
    assign valid_o = $onehot(press);
    assign dir_o   = valid_o ? dir_t'(press) : DIR_NONE;

endmodule

`default_nettype wire

// File: rtl/adventure_engine.sv
// adventure_engine: seven-room walk with sword pickup, saturating move counter, move budget and sticky WIN/DIE.
`default_nettype none

module adventure_engine
    import adventure_pkg::*;
#(
    parameter int MOVE_W    = 8,
    parameter int MAX_MOVES = 20,
    parameter int EDGE_MODE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              N,
    input  logic              S,
    input  logic              E,
    input  logic              W,
    output logic [2:0]        room,
    output logic              sword,
    output logic [MOVE_W-1:0] moves,
    output logic              WIN,
    output logic              DIE
);

    localparam logic [MOVE_W-1:0] MOVES_SAT = '1;
    localparam logic [MOVE_W-1:0] BUDGET    = MOVE_W'(MAX_MOVES);

    logic              press_valid;
    dir_t              press_dir;
    room_t             room_q, room_d, dest;
    logic              sword_q, sword_d;
    logic [MOVE_W-1:0] moves_q, moves_d;
    logic              win_q, win_d, die_q, die_d;

    adventure_dir_decode #(
        .EDGE_MODE (EDGE_MODE)
    ) u_dir_decode (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .btn_i   ({N, S, E, W}),
        .valid_o (press_valid),
        .dir_o   (press_dir)
    );

    always_comb begin
        room_d  = room_q;
        sword_d = sword_q;
        moves_d = moves_q;
        dest    = next_room(room_q, press_dir, sword_q);
        if (room_q == ILLEGAL) begin
            room_d = CAVE;
        end else if (press_valid && (dest != room_q)) begin
            moves_d = (moves_q == MOVES_SAT) ? moves_q : moves_q + 1'b1;
            room_d  = dest;
            // Running out of budget kills the player unless that last move wins.
            if ((MAX_MOVES != 0) && (moves_d == BUDGET) && (dest != VICTORY))
                room_d = DEATH;
            if (room_d == ARMORY)
                sword_d = 1'b1;
        end
        win_d = (room_d == VICTORY);
        die_d = (room_d == DEATH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            room_q  <= CAVE;
            sword_q <= 1'b0;
            moves_q <= '0;
            win_q   <= 1'b0;
            die_q   <= 1'b0;
        end else if (start) begin
            room_q  <= CAVE;
            sword_q <= 1'b0;
            moves_q <= '0;
            win_q   <= 1'b0;
            die_q   <= 1'b0;
        end else begin
            room_q  <= room_d;
            sword_q <= sword_d;
            moves_q <= moves_d;
            win_q   <= win_d;
            die_q   <= die_d;
        end
    end

    assign room  = room_q;
    assign sword = sword_q;
    assign moves = moves_q;
    assign WIN   = win_q;
    assign DIE   = die_q;

endmodule

`default_nettype wire

// File: doc/adventure_engine.md
# adventure_engine

Parametrised, single-clock successor to the room-walking adventure FSM. It decodes N/S/E/W button presses into one move per press, walks a fixed seven-room map, and tracks a sword pickup and a move budget. It drives sticky WIN/DIE outcome flags and sits between the debounced board buttons and the status LED/seven-segment display logic.

## Interface
- MOVE_W, 8, width of the move counter
- MAX_MOVES, 20, move budget; 0 = unlimited; must be < 2**MOVE_W
- EDGE_MODE, 1, 1 = one move per rising edge of a button; 0 = one move per cycle while a button is held (level mode)
- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  synchronous restart pulse; same effect as reset, one cycle later
- N, S, E, W  in  1 each  direction buttons, active-high
- room  out  3  current room code
- sword  out  1  sword held
- moves  out  MOVE_W  executed-move count
- WIN  out  1  sticky, player reached Victory
- DIE  out  1  sticky, player reached Death or exhausted the budget

## Operation
- Room codes: CAVE=0, TUNNEL=1, RIVER=2, ARMORY=3, DRAGON=4, VICTORY=5, DEATH=6. Code 7 is illegal.
- Transitions (unlisted directions are blocked, so room holds and the move is not counted):
  - CAVE: S->TUNNEL
  - TUNNEL: S->RIVER, W->CAVE
  - RIVER: N->TUNNEL, W->ARMORY, E->DRAGON
  - ARMORY: E->RIVER
  - DRAGON: W->ARMORY; E->VICTORY if sword=1, else E->DEATH
  - VICTORY, DEATH: terminal; all input is ignored
- Entering ARMORY sets sword=1. Sword stays set until reset or start.
- A press is valid only if exactly one of N/S/E/W is pressed. Multiple simultaneous presses are ignored and not counted.
- moves increments on each executed (non-blocked) move and saturates at 2**MOVE_W-1.
- Budget: when an executed move makes moves==MAX_MOVES (MAX_MOVES≠0) and the destination is not VICTORY, room is forced to DEATH in the same update. If the final move enters VICTORY, the result is a win.
- WIN=1 iff room==VICTORY. DIE=1 iff room==DEATH. The two are mutually exclusive, and each is sticky until reset or start.
- If room==7 (illegal), the next cycle forces room=CAVE. Sword and moves are untouched.
- Priority order: reset > start > move.

## Timing
- Reset values: room=CAVE, sword=0, moves=0, WIN=0, DIE=0, input registers=0.
- Inputs pass through one register stage (dir_q); EDGE_MODE=1 also keeps dir_qq. press = dir_q & ~dir_qq in edge mode, or dir_q in level mode.
- Latency: a button that rises before edge k gives dir_q=1 after k. room, sword, moves and WIN/DIE update at edge k+1. All outputs are registered.
- Edge mode: a held button yields exactly one move. Release followed by re-press yields another move.
- A start pulse sampled at edge k gives reset values after k. A press in the same cycle is discarded.
- Reset asserted mid-game clears state immediately (asynchronously). The first press after reset release is counted from clean input registers.

## Structure
- Package adventure_pkg holds:
  - room_t enum (3 bits) with the seven codes
  - dir_t one-hot {N,S,E,W}
  - function next_room(room_t, dir_t, sword) returning the destination
- Sub-module adventure_dir_decode contains the input registers, edge/level select, the one-hot validity check, and outputs a press valid/dir_t pair.
- The top level holds the room register, sword flag, move counter, budget check and outcome flags.

## Test plan
- Reset then press S, S, W, E, E, E in edge mode -> rooms 1,2,3,2,4,5. sword=1 after the W press. WIN=1, DIE=0, moves=6.
- From reset press S, S, E, E without visiting ARMORY -> room=DEATH, DIE=1, moves=4. Further presses leave all outputs unchanged.
- Hold S for 10 cycles in edge mode -> exactly one move (room=1, moves=1). Same stimulus with EDGE_MODE=0 -> room=2 (TUNNEL then RIVER), then blocked, moves=2.
- MAX_MOVES=4: press S, W, S, S -> 4th move forces DEATH, DIE=1. MAX_MOVES=6 with the winning path -> WIN=1 on move 6, not DIE.
- Press N and E together in RIVER -> no move, moves unchanged. In CAVE press W -> blocked, moves=0.
- Assert reset mid-path, and separately pulse start while WIN=1 -> room=0, sword=0, moves=0, WIN=DIE=0. A simultaneous press is ignored.
